// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write register file with r0 hardwired to zero, per-register
// pending (scoreboard) bits with a reserve/release handshake, and a one-register-per-cycle clear engine.
// Latency: reads are combinational; writes and reservations land at the next edge; clear takes N-1 cycles plus one DONE cycle.
// Backpressure: rsv_ok=0 (register pending, or clear engine active) leaves all state unchanged and the requester retries.
// Optional: define REGFILE_BYPASS_EN for same-cycle write-to-read bypass (busy masked on a bypass hit).
module regfile_scoreboard #(
  parameter int W = 16,
  parameter int N = 32,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2,
  output logic          busy1,
  output logic          busy2,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_addr,
  output logic          rsv_ok,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  localparam logic [AW-1:0] CNT_FIRST = AW'(1);
  localparam logic [AW-1:0] CNT_LAST  = AW'(N - 1);

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_clr_busy;
  logic          r_clr_done;
  logic [W-1:0]  r_mem [N];
  logic [N-1:0]  r_pend;

  logic w_idle;
  logic w_wr;
  logic w_hit1;
  logic w_hit2;
  logic w_rsv_ok;
  logic w_rsv_set;

  // Writes and reservations are only honoured while the clear engine is idle and out of reset.
  assign w_idle = (r_state == S_IDLE) & ~rst;
  assign w_wr   = w_idle & we & (waddr != '0);

`ifdef REGFILE_BYPASS_EN
  // w_wr already excludes r0, so a hit implies a non-zero read address.
  assign w_hit1 = w_wr & (waddr == raddr1);
  assign w_hit2 = w_wr & (waddr == raddr2);
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  assign rdata1 = rst ? '0 : w_hit1 ? wdata : (raddr1 == '0) ? '0 : r_mem[raddr1];
  assign rdata2 = rst ? '0 : w_hit2 ? wdata : (raddr2 == '0) ? '0 : r_mem[raddr2];
  assign busy1  = ~rst & r_pend[raddr1] & ~w_hit1;
  assign busy2  = ~rst & r_pend[raddr2] & ~w_hit2;

  // A write landing on the same edge releases the register, so it may be re-reserved at once.
  assign w_rsv_ok  = w_idle & rsv_valid &
                     ((rsv_addr == '0) | ~r_pend[rsv_addr] | (we & (waddr == rsv_addr)));
  assign w_rsv_set = w_rsv_ok & (rsv_addr != '0);
  assign rsv_ok    = w_rsv_ok;

  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;

  // Storage and scoreboard: clear engine owns the file in CLEAR; otherwise write releases, reserve sets (reserve wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      r_pend <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[r_cnt]  <= '0;
      r_pend[r_cnt] <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[waddr]  <= wdata;
        r_pend[waddr] <= 1'b0;
      end
      if (w_rsv_set) r_pend[rsv_addr] <= 1'b1;
    end
  end

  // Clear FSM with registered busy/done: walks r1..r(N-1), then one DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_FIRST;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clr_done <= 1'b0;
          if (clr_req) begin
            r_state    <= S_CLEAR;
            r_cnt      <= CNT_FIRST;
            r_clr_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_cnt == CNT_LAST) begin
            r_state    <= S_DONE;
            r_clr_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_cnt      <= CNT_FIRST;
          r_clr_busy <= 1'b0;
          r_clr_done <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= CNT_FIRST;
          r_clr_busy <= 1'b0;
          r_clr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, read/write, r0, bypass, reservations,
// sequential clear timing, and reset in the middle of a clear.
module tb_regfile_scoreboard;
  localparam int W  = 16;
  localparam int N  = 32;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] raddr1, raddr2, waddr, rsv_addr;
  logic [W-1:0]  rdata1, rdata2, wdata;
  logic          busy1, busy2, we, rsv_valid, rsv_ok;
  logic          clr_req, clr_busy, clr_done;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .busy1(busy1), .busy2(busy2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0;
    rsv_valid = 1'b0; rsv_addr = '0; clr_req = 1'b0;
  endtask

  // Ends on the negedge after the write edge.
  task automatic write_reg(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk); we = 1'b1; waddr = a; wdata = d;
    @(negedge clk); we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); raddr1 = 5'd5; raddr2 = 5'd0;
    @(negedge clk);
    we = 1'b1; waddr = 5'd5; wdata = 16'h1234; rsv_valid = 1'b1; rsv_addr = 5'd4;
    #1;
    checks++; if (rdata1 !== 16'h0) begin errors++; $display("FAIL reset_rdata1 got %h exp 0000", rdata1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    checks++; if (rsv_ok !== 1'b0) begin errors++; $display("FAIL reset_rsv_ok got %b exp 0", rsv_ok); end
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy got %b exp 0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done got %b exp 0", clr_done); end
    @(negedge clk); idle_inputs(); rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (rdata1 !== 16'h0) begin errors++; $display("FAIL reset_write_ignored got %h exp 0000", rdata1); end
  endtask

  task automatic test_write_read();
    write_reg(5'd5, 16'h1234);
    raddr1 = 5'd5; #1;
    checks++; if (rdata1 !== 16'h1234) begin errors++; $display("FAIL wr_r5 got %h exp 1234", rdata1); end
    write_reg(5'd0, 16'hFFFF);
    raddr1 = 5'd0; #1;
    checks++; if (rdata1 !== 16'h0) begin errors++; $display("FAIL wr_r0 got %h exp 0000", rdata1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL r0_busy got %b exp 0", busy1); end
  endtask

  task automatic test_bypass();
    write_reg(5'd7, 16'h1111);
    rsv_valid = 1'b1; rsv_addr = 5'd7; #1;
    checks++; if (rsv_ok !== 1'b1) begin errors++; $display("FAIL byp_rsv_ok got %b exp 1", rsv_ok); end
    @(negedge clk); rsv_valid = 1'b0; raddr2 = 5'd7; #1;
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL byp_busy_pre got %b exp 1", busy2); end
    we = 1'b1; waddr = 5'd7; wdata = 16'hBEEF; #1;
    checks++;
    if (rdata2 !== (BYP ? 16'hBEEF : 16'h1111)) begin
      errors++; $display("FAIL byp_rdata2 got %h exp %h", rdata2, (BYP ? 16'hBEEF : 16'h1111));
    end
    checks++;
    if (busy2 !== !BYP) begin errors++; $display("FAIL byp_busy2 got %b exp %b", busy2, !BYP); end
    @(negedge clk); we = 1'b0; #1;
    checks++; if (rdata2 !== 16'hBEEF) begin errors++; $display("FAIL byp_after got %h exp beef", rdata2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL byp_busy_after got %b exp 0", busy2); end
  endtask

  task automatic test_reserve();
    @(negedge clk); rsv_valid = 1'b1; rsv_addr = 5'd9; raddr1 = 5'd9; #1;
    checks++; if (rsv_ok !== 1'b1) begin errors++; $display("FAIL rsv_first got %b exp 1", rsv_ok); end
    @(negedge clk); #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rsv_busy got %b exp 1", busy1); end
    checks++; if (rsv_ok !== 1'b0) begin errors++; $display("FAIL rsv_again got %b exp 0", rsv_ok); end
    @(negedge clk); rsv_valid = 1'b0; we = 1'b1; waddr = 5'd9; wdata = 16'h0042; #1;
    checks++;
    if (busy1 !== !BYP) begin errors++; $display("FAIL rsv_busy_wr got %b exp %b", busy1, !BYP); end
    @(negedge clk); we = 1'b0; #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rsv_release got %b exp 0", busy1); end
    checks++; if (rdata1 !== 16'h0042) begin errors++; $display("FAIL rsv_data got %h exp 0042", rdata1); end
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    @(negedge clk); we = 1'b1; waddr = 5'd9; wdata = 16'h0055; #1;
    checks++; if (rsv_ok !== 1'b1) begin errors++; $display("FAIL rsv_wr_same got %b exp 1", rsv_ok); end
    @(negedge clk); we = 1'b0; rsv_valid = 1'b0; #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rsv_wr_pend got %b exp 1", busy1); end
    checks++; if (rdata1 !== 16'h0055) begin errors++; $display("FAIL rsv_wr_data got %h exp 0055", rdata1); end
    rsv_valid = 1'b1; rsv_addr = 5'd0; raddr1 = 5'd0; #1;
    checks++; if (rsv_ok !== 1'b1) begin errors++; $display("FAIL rsv_r0 got %b exp 1", rsv_ok); end
    @(negedge clk); rsv_valid = 1'b0; #1;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rsv_r0_busy got %b exp 0", busy1); end
  endtask

  task automatic test_clear();
    int busy_cnt, done_cnt, done_cyc, bad;
    for (int i = 1; i < N; i++) begin
      @(negedge clk); we = 1'b1; waddr = AW'(i); wdata = 16'h00AA;
    end
    @(negedge clk); we = 1'b0; rsv_valid = 1'b1; rsv_addr = 5'd3;
    @(negedge clk); rsv_valid = 1'b0; raddr1 = 5'd3; raddr2 = 5'd31; #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL clr_pre_busy got %b exp 1", busy1); end
    checks++; if (rdata2 !== 16'h00AA) begin errors++; $display("FAIL clr_pre_fill got %h exp 00aa", rdata2); end
    clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      we = (c == 25); waddr = 5'd5; wdata = 16'h7777;
      rsv_valid = (c == 25); rsv_addr = 5'd6;
      clr_req = (c == 10);
      if (c == 5) begin raddr1 = 5'd30; raddr2 = 5'd2; end
      #1;
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) begin done_cnt++; done_cyc = c; end
      if (c == 5) begin
        checks++; if (rdata1 !== 16'h00AA) begin errors++; $display("FAIL clr_live_old got %h exp 00aa", rdata1); end
        checks++; if (rdata2 !== 16'h0) begin errors++; $display("FAIL clr_live_new got %h exp 0000", rdata2); end
      end
      if (c == 25) begin
        checks++; if (rsv_ok !== 1'b0) begin errors++; $display("FAIL clr_rsv_ok got %b exp 0", rsv_ok); end
      end
      @(negedge clk);
    end
    idle_inputs();
    checks++; if (busy_cnt !== 32) begin errors++; $display("FAIL clr_busy_cycles got %0d exp 32", busy_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL clr_done_pulses got %0d exp 1", done_cnt); end
    checks++; if (done_cyc !== 32) begin errors++; $display("FAIL clr_done_cycle got %0d exp 32", done_cyc); end
    for (int i = 0; i < N; i++) begin
      raddr1 = AW'(i); raddr2 = AW'(i); #1;
      bad = (rdata1 !== 16'h0 || busy1 !== 1'b0 || busy2 !== 1'b0) ? 1 : 0;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL clr_reg%0d got %h/%b exp 0000/0", i, rdata1, busy1); end
    end
    raddr1 = 5'd5; #1;
    checks++; if (rdata1 !== 16'h0) begin errors++; $display("FAIL clr_write_dropped got %h exp 0000", rdata1); end
  endtask

  task automatic test_reset_mid_clear();
    int busy_seen, done_seen;
    bit finished;
    write_reg(5'd15, 16'h00AA);
    clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clk);
    #1;
    checks++; if (clr_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b exp 1", clr_busy); end
    rst = 1'b1; raddr1 = 5'd15; #1;
    checks++; if (clr_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_rst got %b exp 0", clr_busy); end
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL mid_done_rst got %b exp 0", clr_done); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (rdata1 !== 16'h0) begin errors++; $display("FAIL mid_r15 got %h exp 0000", rdata1); end
    busy_seen = 0; done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (clr_busy !== 1'b0) busy_seen++;
      if (clr_done !== 1'b0) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL mid_no_done got %0d exp 0", done_seen); end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL mid_no_busy got %0d exp 0", busy_seen); end
    write_reg(5'd1, 16'h0011);
    write_reg(5'd2, 16'h0022);
    clr_req = 1'b1;
    @(negedge clk); clr_req = 1'b0;
    @(negedge clk); raddr1 = 5'd1; raddr2 = 5'd2; #1;
    checks++; if (rdata1 !== 16'h0) begin errors++; $display("FAIL restart_r1 got %h exp 0000", rdata1); end
    checks++; if (rdata2 !== 16'h0022) begin errors++; $display("FAIL restart_r2 got %h exp 0022", rdata2); end
    finished = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      @(negedge clk); #1;
      if (clr_busy === 1'b0) finished = 1'b1;
    end
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL restart_timeout got %b exp 1", finished); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    raddr1 = '0; raddr2 = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_reserve();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
